// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants and the immediate-format codes for the decode-stage immediate generator.
package imm_pkg;

  localparam int IMM_TYPE_W = 4;
  localparam int INST_W     = 32;

  typedef enum logic [IMM_TYPE_W-1:0] {
    IMM_I     = 4'd0,
    IMM_NONE  = 4'd1,
    IMM_S     = 4'd2,
    IMM_B     = 4'd3,
    IMM_U     = 4'd4,
    IMM_J     = 4'd5,
    IMM_Z     = 4'd6,
    IMM_SHAMT = 4'd7,
    IMM_CI    = 4'd8,
    IMM_CLW   = 4'd9,
    IMM_CB    = 4'd10,
    IMM_CJ    = 4'd11
  } imm_type_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate expansion: (inst, format code) -> {imm, illegal}.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b1
) (
  input  logic [INST_W-1:0]     inst,
  input  logic [IMM_TYPE_W-1:0] imm_type,
  output logic [XLEN-1:0]       imm,
  output logic                  illegal
);

  // Everything is built at 64 bits so sign extension is uniform, then cut to XLEN.
  logic [63:0] imm64;
  logic        unused_bits;

  always_comb begin
    imm64   = 64'h0;
    illegal = 1'b0;
    case (imm_type)
      IMM_I:     imm64 = {{52{inst[31]}}, inst[31:20]};
      IMM_NONE:  imm64 = 64'h0;
      IMM_S:     imm64 = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     imm64 = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     imm64 = {{32{inst[31]}}, inst[31:12], 12'h000};
      IMM_J:     imm64 = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:     imm64 = {59'h0, inst[19:15]};
      IMM_SHAMT: imm64 = (XLEN == 64) ? {58'h0, inst[25:20]} : {59'h0, inst[24:20]};
      IMM_CI: begin
        if (RVC_EN) imm64 = {{58{inst[12]}}, inst[12], inst[6:2]};
        else        illegal = 1'b1;
      end
      IMM_CLW: begin
        if (RVC_EN) imm64 = {57'h0, inst[5], inst[12:10], inst[6], 2'b00};
        else        illegal = 1'b1;
      end
      IMM_CB: begin
        if (RVC_EN) imm64 = {{55{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                             inst[4:3], 1'b0};
        else        illegal = 1'b1;
      end
      IMM_CJ: begin
        if (RVC_EN) imm64 = {{52{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                             inst[2], inst[11], inst[5:3], 1'b0};
        else        illegal = 1'b1;
      end
      default:   illegal = 1'b1;
    endcase
  end

  assign imm = imm64[XLEN-1:0];

  // Opcode bits [1:0] never feed an immediate; upper imm64 bits are dropped for XLEN=32.
  assign unused_bits = ^{inst[1:0], imm64};

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with one-cycle latency and a main + skid output buffer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_W-1:0]     in_inst,
  input  logic [IMM_TYPE_W-1:0] in_imm_type,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_imm,
  output logic                  out_illegal
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  logic            main_valid;
  logic [XLEN-1:0] main_imm;
  logic            main_illegal;
  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic            skid_illegal;

  logic            accept;
  logic            drain;

  imm_decode #(
    .XLEN   (XLEN),
    .RVC_EN (RVC_EN)
  ) u_decode (
    .inst     (in_inst),
    .imm_type (in_imm_type),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  // Ready is a pure function of registered state, so out_ready never reaches in_ready.
  assign in_ready = !skid_valid && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid   <= 1'b0;
      main_imm     <= '0;
      main_illegal <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_illegal <= 1'b0;
    end else if (drain) begin
      // A full buffer cannot accept, so a skid refill and a new beat never collide.
      if (skid_valid) begin
        main_imm     <= skid_imm;
        main_illegal <= skid_illegal;
        skid_valid   <= 1'b0;
      end else if (accept) begin
        main_imm     <= dec_imm;
        main_illegal <= dec_illegal;
      end else begin
        main_valid   <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_valid   <= 1'b1;
        main_imm     <= dec_imm;
        main_illegal <= dec_illegal;
      end else begin
        skid_valid   <= 1'b1;
        skid_imm     <= dec_imm;
        skid_illegal <= dec_illegal;
      end
    end
  end

  assign out_valid   = main_valid;
  assign out_imm     = main_imm;
  assign out_illegal = main_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three parameterisations driven from one stimulus stream.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [3:0]  in_imm_type;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm;
  logic        n_in_ready, n_out_valid, n_out_illegal;
  logic [31:0] n_out_imm;
  logic        w_in_ready, w_out_valid, w_out_illegal;
  logic [63:0] w_out_imm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .RVC_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_imm_type(in_imm_type), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_imm(a_out_imm), .out_illegal(a_out_illegal));

  imm_gen_pipe #(.XLEN(32), .RVC_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_inst(in_inst), .in_imm_type(in_imm_type), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_imm(n_out_imm), .out_illegal(n_out_illegal));

  imm_gen_pipe #(.XLEN(64), .RVC_EN(1'b1)) dut_w (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_inst(in_inst), .in_imm_type(in_imm_type), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_imm(w_out_imm), .out_illegal(w_out_illegal));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge, then idle the input.
  task automatic send(input logic [31:0] inst, input logic [3:0] typ);
    in_valid    = 1'b1;
    in_inst     = inst;
    in_imm_type = typ;
    step();
    in_valid    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_imm_type = 4'd0;
    step(); step();
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_imm", a_out_imm, 0);
    chk("rst_out_illegal", a_out_illegal, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", a_in_ready, 1);

    send(32'hFFF00093, 4'd0);
    chk("i_valid", a_out_valid, 1);
    chk("i_imm32", a_out_imm, 64'hFFFFFFFF);
    chk("i_ill", a_out_illegal, 0);
    chk("i_imm64", w_out_imm, 64'hFFFFFFFFFFFFFFFF);
    step();
    chk("i_drained", a_out_valid, 0);

    send(32'hFE000EE3, 4'd3);
    chk("b_imm", a_out_imm, 64'hFFFFFFFC);

    send(32'h0000BFFD, 4'd11);
    chk("cj_imm", a_out_imm, 64'hFFFFFFFE);
    chk("cj_ill", a_out_illegal, 0);
    chk("cj_norvc_valid", n_out_valid, 1);
    chk("cj_norvc_imm", n_out_imm, 0);
    chk("cj_norvc_ill", n_out_illegal, 1);

    send(32'h800000B7, 4'd4);
    chk("u_imm64", w_out_imm, 64'hFFFFFFFF80000000);
    chk("u_imm32", a_out_imm, 64'h80000000);

    send(32'h03F00000, 4'd7);
    chk("shamt64", w_out_imm, 64'h3F);
    chk("shamt32", a_out_imm, 64'h1F);

    send(32'hFFFFFFFF, 4'd13);
    chk("bad_code_imm", a_out_imm, 0);
    chk("bad_code_ill", a_out_illegal, 1);
    chk("bad_code_valid", a_out_valid, 1);

    send(32'h000F8000, 4'd6);
    chk("z_imm", a_out_imm, 64'h1F);
    send(32'h02000200, 4'd2);
    chk("s_imm", a_out_imm, 64'h24);
    send(32'h00001C60, 4'd9);
    chk("clw_imm", a_out_imm, 64'h7C);
    send(32'h00001004, 4'd8);
    chk("ci_imm", a_out_imm, 64'hFFFFFFE1);
    send(32'h00000020, 4'd10);
    chk("cb_imm", a_out_imm, 64'h40);
    send(32'h00100000, 4'd5);
    chk("j_imm", a_out_imm, 64'h800);
    send(32'h00000000, 4'd1);
    chk("none_imm", a_out_imm, 0);
    chk("none_ill", a_out_illegal, 0);
    step();

    // Streaming: one beat per cycle with out_ready held high.
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_imm_type = 4'd0; in_inst = {k[11:0], 20'h00093};
      step();
      chk("stream_valid", a_out_valid, 1);
      chk("stream_imm", a_out_imm, 64'(k));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", a_out_valid, 0);

    // Backpressure: beats 1,2,3 while stalled.
    out_ready = 1'b0;
    send(32'h00100093, 4'd0);
    chk("bp_ready_after1", a_in_ready, 1);
    send(32'h00200093, 4'd0);
    chk("bp_ready_after2", a_in_ready, 0);
    chk("bp_head", a_out_imm, 1);
    in_valid = 1'b1; in_inst = 32'h00300093; in_imm_type = 4'd0;
    step();
    chk("bp_held_ready", a_in_ready, 0);
    chk("bp_stable_imm", a_out_imm, 1);
    chk("bp_stable_valid", a_out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("bp_out2", a_out_imm, 2);
    chk("bp_ready_reopen", a_in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_out3", a_out_imm, 3);
    chk("bp_out3_valid", a_out_valid, 1);
    step();
    chk("bp_empty", a_out_valid, 0);

    // Flush with both entries full and a beat offered.
    out_ready = 1'b0;
    send(32'h00500093, 4'd0);
    send(32'h00600093, 4'd0);
    in_valid = 1'b1; in_inst = 32'h00700093; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_full_valid", a_out_valid, 0);
    chk("flush_full_ready", a_in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("flush_full_no_out", a_out_valid, 0);

    // Flush beats a same-cycle accept even while in_ready is high.
    out_ready = 1'b0;
    send(32'h00800093, 4'd0);
    in_valid = 1'b1; in_inst = 32'h00900093; flush = 1'b1;
    #1;
    chk("flush_part_ready", a_in_ready, 1);
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_part_valid", a_out_valid, 0);
    out_ready = 1'b1;
    step();
    chk("flush_part_no_out", a_out_valid, 0);

    // Reset in the middle of a stall.
    out_ready = 1'b0;
    send(32'h00A00093, 4'd0);
    send(32'h00B00093, 4'd0);
    in_valid = 1'b1; in_inst = 32'h00C00093; rst = 1'b1;
    step();
    chk("rst_stall_ready", a_in_ready, 0);
    in_valid = 1'b0; rst = 1'b0;
    #1;
    chk("rst_stall_valid", a_out_valid, 0);
    chk("rst_stall_imm", a_out_imm, 0);
    chk("rst_stall_ready_after", a_in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("rst_stall_no_out", a_out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
